// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: one-shot mult/div with modelled busy latency,
// HI/LO architectural registers, and single-cycle mthi/mtlo writes.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_op_e      op;
  state_e      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  md_res_t     pend, pend_n, res;
  logic [31:0] hi_n, lo_n;
  logic        is_md, is_mul;

  assign op     = md_op_e'(MDOp);
  assign is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign Busy   = (state == RUN);
  assign Start  = is_md && !Busy;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, den_u, q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign den_s  = (B == 32'd0) ? 32'd1 : b_mag;
  assign den_u  = (B == 32'd0) ? 32'd1 : B;
  assign q_mag  = a_mag / den_s;
  assign r_mag  = a_mag % den_s;
  assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = A / den_u;
  assign r_u    = A % den_u;

  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], wr: 1'b1};
      OP_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], wr: 1'b1};
      OP_DIV:   res = '{hi: r_s, lo: q_s, wr: (B != 32'd0)};
      OP_DIVU:  res = '{hi: r_u, lo: q_u, wr: (B != 32'd0)};
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    hi_n    = HI;
    lo_n    = LO;
    case (state)
      IDLE: begin
        if (Start) begin
          pend_n  = res;
          cnt_n   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_n = RUN;
        end else if (op == OP_MTHI) begin
          hi_n = A;
        end else if (op == OP_MTLO) begin
          lo_n = A;
        end
      end
      RUN: begin
        // Any op arriving here is dropped; only the countdown advances.
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          pend_n  = '0;
          if (pend.wr) begin
            hi_n = pend.hi;
            lo_n = pend.lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops against an
// arithmetic reference model of HI/LO and busy latency.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  mdop;
  logic        start, busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .MDOp(mdop),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    wr = 1'b1; rh = '0; rl = '0;
    case (op)
      3'd1: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'd3: if (y == 0) wr = 1'b0; else begin rl = 32'(sx / sy); rh = 32'(sx % sy); end
      3'd4: if (y == 0) wr = 1'b0; else begin rl = x / y; rh = x % y; end
      default: wr = 1'b0;
    endcase
  endfunction

  // Presents one op at the current cycle (Busy assumed 0) and follows it to completion.
  // inj enables illegal ops during busy cycles 2 and 3.
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit inj);
    logic [31:0] rh, rl;
    bit wr;
    int n;
    mdop = op; a = x; b = y;
    #1;
    chk("start", {31'd0, start}, {31'd0, (op >= 3'd1 && op <= 3'd4)});
    chk("busy_pre", {31'd0, busy}, 32'd0);
    if (op >= 3'd1 && op <= 3'd4) begin
      ref_md(op, x, y, rh, rl, wr);
      n = (op <= 3'd2) ? MC : DC;
      tick();
      mdop = 3'd0;
      for (int i = 1; i <= n; i++) begin
        if (inj && i == 2) begin mdop = 3'd6; a = 32'h0000DEAD; end
        if (inj && i == 3) begin mdop = 3'd3; a = 32'd9; b = 32'd4; end
        #1;
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("start_run", {31'd0, start}, 32'd0);
        chk("hi_hold", hi, m_hi);
        chk("lo_hold", lo, m_lo);
        tick();
        mdop = 3'd0;
      end
      if (wr) begin m_hi = rh; m_lo = rl; end
    end else begin
      tick();
      mdop = 3'd0;
      if (op == 3'd5) m_hi = x;
      if (op == 3'd6) m_lo = x;
    end
    #1;
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    #1;
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b1; mdop = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    do_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    do_op(3'd4, 32'd7, 32'd2, 1'b0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    do_op(3'd5, 32'h12345678, 32'd0, 1'b0);
    do_op(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
    do_op(3'd4, 32'd55, 32'd0, 1'b0);
    chk("dz_hi", hi, 32'h12345678);
    chk("dz_lo", lo, 32'h9ABCDEF0);
    do_op(3'd1, 32'd1000, 32'hFFFFFF00, 1'b1);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      do_op(rop, ra, rb, k[0]);
    end

    // Asynchronous reset in the third busy cycle of div 100/7.
    mdop = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    mdop = 3'd0;
    tick();
    tick();
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_hi", hi, 32'd0);
    chk("async_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DC; i++) tick();
    #1;
    chk("no_wb_hi", hi, 32'd0);
    chk("no_wb_lo", lo, 32'd0);
    chk("no_wb_busy", {31'd0, busy}, 32'd0);
    tick();
    do_op(3'd1, 32'd2, 32'd3, 1'b0);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
